// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among
// NREQ requesters; results come back tagged with the owning requester id.
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ*3-1:0]     op_sel,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  res_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   win;
    logic             hit;
    logic             arb;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   res_id_q;
    logic             err_q;
    logic [WIDTH-1:0] alu;
    logic             alu_err;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!hit && req[(int'(last_q) + k) % NREQ]) begin
                hit = 1'b1;
                win = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    assign arb = hit && (state_q != GNT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = arb ? GNT : IDLE;
            GNT:     state_d = RSP;
            RSP:     state_d = arb ? GNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu     = '0;
        alu_err = 1'b0;
        unique case (sel_q)
            3'd0: alu = a_q & b_q;
            3'd1: alu = a_q | b_q;
            3'd2: alu = ~(a_q & b_q);
            3'd3: alu = ~(a_q | b_q);
            3'd4: alu = a_q ^ b_q;
            3'd5: alu = ~(a_q ^ b_q);
            3'd6: alu = ~a_q;
            3'd7: alu_err = 1'b1;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            res_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (arb) begin
                last_q <= win;
                id_q   <= win;
                a_q    <= op_a[int'(win)*WIDTH +: WIDTH];
                b_q    <= op_b[int'(win)*WIDTH +: WIDTH];
                sel_q  <= op_sel[int'(win)*3 +: 3];
            end
            if (state_q == GNT) begin
                data_q   <= alu;
                res_id_q <= id_q;
                err_q    <= alu_err;
            end
        end
    end

    assign gnt       = (state_q == GNT) ? (NREQ'(1) << id_q) : '0;
    assign res_valid = (state_q == RSP);
    assign res_err   = res_valid & err_q;
    assign res_data  = data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with hand-computed expectations.
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [11:0] op_sel;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_err;
    logic        busy;

    int n_vec;
    int n_err;

    logic_unit_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .op_a(op_a),
        .op_b(op_b),
        .op_sel(op_sel),
        .gnt(gnt),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_id(res_id),
        .res_err(res_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] sel);
        op_a[id*8 +: 8]   = a;
        op_b[id*8 +: 8]   = b;
        op_sel[id*3 +: 3] = sel;
    endtask

    // Called at a negedge; returns at the negedge of the result cycle.
    task automatic do_op(input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sel,
                         input logic [7:0] ed, input logic ee);
        set_op(id, a, b, sel);
        req = 4'b0001 << id;
        @(posedge clk);
        @(negedge clk);
        chk("op_gnt", {28'd0, gnt}, {28'd0, 4'b0001 << id});
        chk("op_novalid", {31'd0, res_valid}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("op_valid", {31'd0, res_valid}, 32'd1);
        chk("op_data", {24'd0, res_data}, {24'd0, ed});
        chk("op_id", {30'd0, res_id}, id);
        chk("op_err", {31'd0, res_err}, {31'd0, ee});
    endtask

    initial begin
        logic [7:0] exp_tab [7];
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        req    = 4'b1111;
        op_a   = '0;
        op_b   = '0;
        op_sel = '0;
        exp_tab = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F};

        // reset with all requests held
        repeat (3) @(negedge clk);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", {24'd0, res_data}, 32'd0);
        chk("rst_id", {30'd0, res_id}, 32'd0);
        chk("rst_err", {31'd0, res_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_gnt", {28'd0, gnt}, 32'd1);
        chk("first_busy", {31'd0, busy}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("first_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // requester 0 through every defined opcode
        for (int s = 0; s < 7; s++) begin
            do_op(0, 8'hF0, 8'hCC, 3'(s), exp_tab[s], 1'b0);
        end
        @(negedge clk);

        // fresh pointer, then all requesters continuously
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(i, 8'h11 * 8'(i + 1), 8'h0F, 3'd0);
        end
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr_gnt", {28'd0, gnt}, {28'd0, 4'b0001 << (i % 4)});
            chk("rr_gnt_novalid", {31'd0, res_valid}, 32'd0);
            chk("rr_busy_g", {31'd0, busy}, 32'd1);
            if (i == 7) req = 4'b0000;
            @(negedge clk);
            chk("rr_valid", {31'd0, res_valid}, 32'd1);
            chk("rr_id", {30'd0, res_id}, i % 4);
            chk("rr_data", {24'd0, res_data}, (i % 4) + 1);
            chk("rr_busy_r", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);

        // reserved opcode, then a normal op
        do_op(2, 8'hFF, 8'h00, 3'd7, 8'h00, 1'b1);
        do_op(1, 8'hAA, 8'hAA, 3'd0, 8'hAA, 1'b0);
        @(negedge clk);
        chk("err_cleared", {31'd0, res_err}, 32'd0);

        // operands captured at grant
        set_op(1, 8'h0F, 8'h00, 3'd6);
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        chk("cap_gnt", {28'd0, gnt}, 32'd2);
        op_a[15:8] = 8'hFF;
        req = 4'b0000;
        @(negedge clk);
        chk("cap_valid", {31'd0, res_valid}, 32'd1);
        chk("cap_data", {24'd0, res_data}, 32'hF0);
        @(negedge clk);

        // reset during RSP of a requester 1 operation
        set_op(1, 8'h12, 8'h34, 3'd4);
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("mid_valid_pre", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("mid_busy_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("post_rst_data", {24'd0, res_data}, 32'd0);
        req = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_gnt", {28'd0, gnt}, 32'd2);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered WIDTH-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) among NREQ requesters.
- Arbitration is round-robin. Each granted operation latches its operands, computes the result in a single cycle, and returns it tagged with the requester id.
- Sits between the gate-level datapath and the blocks that need bitwise results, so the unit is instantiated once per cluster rather than once per consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester id width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester; held high until its gnt bit is seen.
- op_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b  in  NREQ*WIDTH  operand B, same packing.
- op_sel  in  NREQ*3  opcode per requester, packed [i*3 +: 3].
- gnt  out  NREQ  one-hot grant pulse, one cycle.
- res_valid  out  1  result valid, one-cycle pulse.
- res_data  out  WIDTH  result.
- res_id  out  IDW  index of the requester that owns res_data.
- res_err  out  1  reserved opcode flag, qualified by res_valid.
- busy  out  1  high in GNT and RSP states.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, res_valid=0, res_data=0, res_id=0, res_err=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - Operand latches cleared.
  - Release is synchronous to the next clk edge. No output toggles while rst_n=0.
- FSM states: IDLE, GNT, RSP.
  - IDLE: if any req is high at the edge → GNT; otherwise stay in IDLE.
  - GNT: unconditionally → RSP.
  - RSP: if any req is high at the edge → GNT (back-to-back); otherwise → IDLE.
- Arbitration (IDLE or RSP edge with req≠0):
  - Winner w is the first set req bit scanning last+1, last+2, … modulo NREQ.
  - At that edge: gnt=onehot(w), last=w, and latch a_q=op_a[w], b_q=op_b[w], sel_q=op_sel[w], id_q=w.
  - req is not sampled in GNT.
- Compute (GNT→RSP edge): res_valid=1, res_id=id_q, and res_data from sel_q:
  - 0 AND a&b; 1 OR a|b; 2 NAND ~(a&b); 3 NOR ~(a|b).
  - 4 XOR a^b; 5 XNOR ~(a^b); 6 NOT ~a (b ignored).
  - 7 reserved: res_data=0, res_err=1.
- Pulse widths and holds:
  - gnt is high only during GNT.
  - res_valid and res_err are high only during RSP.
  - res_data and res_id hold their last value after RSP until the next RSP.
- Timing:
  - Latency: req sampled at edge E0, gnt high E0–E1, res_valid high E1–E2.
  - Throughput: one operation per 2 cycles under continuous requests.
- Requester rule:
  - Drop req (or present new operands) by the edge that ends its gnt cycle.
  - A requester may re-request in the RSP cycle. Fairness still places it behind the other pending requesters.
- Operands are captured at grant. Changes to op_a/op_b/op_sel after the grant edge do not affect the result.
- Width rule: all operations are bitwise on WIDTH bits, with no carries or extension.
- Boundary cases:
  - Single requester repeatedly asserting: it is served every 2 cycles.
  - All requesters asserting: service order is 0,1,2,3,0,…
  - Pointer wraps from NREQ-1 to 0.
  - req bits ≥ NREQ do not exist. Opcode 7 never stalls the FSM.
- Reset mid-operation (in GNT or RSP): the in-flight operation is discarded, no res_valid is produced, and the pointer returns to NREQ-1.

Test Plan:
- Reset with req=4'b1111 held → all outputs 0 while rst_n=0. The first grant after release is gnt=0001.
- Requester 0 issues a=8'hF0, b=8'hCC at each of sel=0..6 in turn → res_data=C0, FC, 3F, 03, 3C, C3, 0F. res_id=0, each result 1 cycle after its gnt.
- req=1111 held for 8 operations → gnt order 0,1,2,3,0,1,2,3. res_valid toggles every other cycle, and busy stays 1 throughout.
- Requester 2 issues op_sel=7 with a=8'hFF → res_data=00, res_err=1, res_id=2. The next operation from requester 1 (sel=0, a=b=8'hAA) returns AA with res_err=0.
- Requester 1 changes op_a from 8'h0F to 8'hFF the cycle after gnt, with sel=6 → res_data=F0, computed from the captured operand.
- Assert rst_n=0 during RSP → res_valid drops immediately, no further result appears, and the next grant with req=0110 goes to requester 1.
